// File: rtl/voice_transformer_top.sv
// WM8731-style codec front end: one-shot I2C register setup plus an I2S
// loopback that replays the last complete left sample on both DAC channels.
module voice_transformer_top (
   input  logic       mclk,
   input  logic       rst,
   output logic       sclk,
   inout  wire        sdat,
   input  logic       bclk,
   input  logic       adclrc,
   input  logic       daclrc,
   input  logic       adcdat,
   output logic       dacdat,
   output logic [1:0] channel
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_ADDR  = 3'd2;
   localparam logic [2:0] S_BHI   = 3'd3;
   localparam logic [2:0] S_BLO   = 3'd4;
   localparam logic [2:0] S_STOP  = 3'd5;
   localparam logic [2:0] S_GAP   = 3'd6;
   localparam logic [2:0] S_DONE  = 3'd7;

   // Sync vector order: {adcdat, daclrc, adclrc, bclk}
   logic [3:0]  r_s1, r_s2;
   logic [2:0]  r_prev;
   logic        w_bclk_rise, w_bclk_fall, w_adc_edge, w_dac_rise, w_dac_fall;
   logic        w_adc_bit, w_adc_left;

   logic [4:0]  r_rx_cnt;
   logic [15:0] r_rx_sr, r_rx_left;
   logic [4:0]  r_tx_cnt;
   logic [15:0] r_tx_sr, r_dac_word;
   logic        r_dacdat;

   logic [4:0]  r_div;
   logic [2:0]  r_state;
   logic [1:0]  r_q;
   logic [3:0]  r_bit, r_word;
   logic        r_sclk, r_sda_oe;
   logic        w_tick, w_scl_nxt, w_sda_low_nxt, w_done;
   logic [15:0] w_cfg;
   logic [7:0]  w_byte;

   always_ff @(posedge mclk) begin
      if (!rst) begin
         r_s1   <= '0;
         r_s2   <= '0;
         r_prev <= '0;
      end else begin
         r_s1   <= {adcdat, daclrc, adclrc, bclk};
         r_s2   <= r_s1;
         r_prev <= r_s2[2:0];
      end
   end

   assign w_bclk_rise = r_s2[0] & ~r_prev[0];
   assign w_bclk_fall = ~r_s2[0] & r_prev[0];
   assign w_adc_edge  = r_s2[1] ^ r_prev[1];
   assign w_dac_rise  = r_s2[2] & ~r_prev[2];
   assign w_dac_fall  = ~r_s2[2] & r_prev[2];
   assign w_adc_bit   = r_s2[3];
   assign w_adc_left  = ~r_s2[1];

   // rx count: 0 = skip slot after LR edge, 1..16 = bits 15..0, 17 = idle
   always_ff @(posedge mclk) begin
      if (!rst) begin
         r_rx_cnt  <= 5'd17;
         r_rx_sr   <= '0;
         r_rx_left <= '0;
      end else if (w_adc_edge) begin
         r_rx_cnt <= 5'd0;
      end else if (w_bclk_rise && r_rx_cnt != 5'd17) begin
         r_rx_cnt <= r_rx_cnt + 5'd1;
         if (r_rx_cnt != 5'd0)
            r_rx_sr <= {r_rx_sr[14:0], w_adc_bit};
         if (r_rx_cnt == 5'd16 && w_adc_left)
            r_rx_left <= {r_rx_sr[14:0], w_adc_bit};
      end
   end

   // The bclk fall coinciding with the LR edge is the skipped slot, so the
   // MSB goes out on the next fall. r_dac_word holds the sample for both halves.
   always_ff @(posedge mclk) begin
      if (!rst) begin
         r_tx_sr    <= '0;
         r_dac_word <= '0;
         r_tx_cnt   <= 5'd16;
         r_dacdat   <= 1'b0;
      end else if (w_dac_fall) begin
         r_dac_word <= r_rx_left;
         r_tx_sr    <= r_rx_left;
         r_tx_cnt   <= 5'd0;
         r_dacdat   <= 1'b0;
      end else if (w_dac_rise) begin
         r_tx_sr  <= r_dac_word;
         r_tx_cnt <= 5'd0;
         r_dacdat <= 1'b0;
      end else if (w_bclk_fall) begin
         if (r_tx_cnt != 5'd16) begin
            r_dacdat <= r_tx_sr[15];
            r_tx_sr  <= {r_tx_sr[14:0], 1'b0};
            r_tx_cnt <= r_tx_cnt + 5'd1;
         end else begin
            r_dacdat <= 1'b0;
         end
      end
   end

   always_comb begin
      case (r_word)
         4'd0:    w_cfg = 16'h1E00;
         4'd1:    w_cfg = 16'h0017;
         4'd2:    w_cfg = 16'h0217;
         4'd3:    w_cfg = 16'h0812;
         4'd4:    w_cfg = 16'h0A00;
         4'd5:    w_cfg = 16'h0C00;
         4'd6:    w_cfg = 16'h0E42;
         4'd7:    w_cfg = 16'h1000;
         default: w_cfg = 16'h1201;
      endcase
      case (r_state)
         S_ADDR:  w_byte = 8'h34;
         S_BHI:   w_byte = w_cfg[15:8];
         S_BLO:   w_byte = w_cfg[7:0];
         default: w_byte = 8'h00;
      endcase
   end

   assign w_tick = (r_div == 5'd31);

   // Each bit is four quarter ticks: r_q 0 = SCL low (data changes), 1-2 high, 3 low.
   always_ff @(posedge mclk) begin
      if (!rst) begin
         r_div   <= '0;
         r_state <= S_IDLE;
         r_q     <= '0;
         r_bit   <= '0;
         r_word  <= '0;
      end else begin
         r_div <= r_div + 5'd1;
         if (w_tick) begin
            case (r_state)
               S_IDLE: r_state <= S_START;
               S_DONE: ;
               default: begin
                  r_q <= r_q + 2'd1;
                  if (r_q == 2'd3) begin
                     case (r_state)
                        S_START: begin
                           r_state <= S_ADDR;
                           r_bit   <= '0;
                        end
                        S_ADDR, S_BHI, S_BLO: begin
                           if (r_bit == 4'd8) begin
                              r_state <= r_state + 3'd1;
                              r_bit   <= '0;
                           end else begin
                              r_bit <= r_bit + 4'd1;
                           end
                        end
                        S_STOP: begin
                           r_state <= S_GAP;
                           r_bit   <= '0;
                        end
                        S_GAP: begin
                           if (r_bit == 4'd3) begin
                              r_bit <= '0;
                              if (r_word == 4'd8) begin
                                 r_state <= S_DONE;
                              end else begin
                                 r_word  <= r_word + 4'd1;
                                 r_state <= S_START;
                              end
                           end else begin
                              r_bit <= r_bit + 4'd1;
                           end
                        end
                        default: ;
                     endcase
                  end
               end
            endcase
         end
      end
   end

   always_comb begin
      w_scl_nxt     = 1'b1;
      w_sda_low_nxt = 1'b0;
      case (r_state)
         S_START: begin
            w_scl_nxt     = (r_q != 2'd3);
            w_sda_low_nxt = (r_q != 2'd0);
         end
         S_ADDR, S_BHI, S_BLO: begin
            w_scl_nxt     = (r_q == 2'd1) || (r_q == 2'd2);
            w_sda_low_nxt = (r_bit != 4'd8) && !w_byte[3'd7 - r_bit[2:0]];
         end
         S_STOP: begin
            w_scl_nxt     = (r_q != 2'd0);
            w_sda_low_nxt = (r_q < 2'd2);
         end
         default: ;
      endcase
   end

   always_ff @(posedge mclk) begin
      if (!rst) begin
         r_sclk   <= 1'b1;
         r_sda_oe <= 1'b0;
      end else begin
         r_sclk   <= w_scl_nxt;
         r_sda_oe <= w_sda_low_nxt;
      end
   end

   assign w_done  = (r_state == S_DONE);
   assign sclk    = r_sclk;
   assign sdat    = r_sda_oe ? 1'b0 : 1'bz;
   assign dacdat  = r_dacdat;
   assign channel = {w_done, r_s2[2]};

endmodule

// File: tb/tb_voice_transformer_top.sv
// Bench for voice_transformer_top: I2C byte decoder and I2S word scoreboard
// running beside directed frame stimulus.
module tb_voice_transformer_top;

   logic       mclk = 1'b0;
   logic       rst = 1'b0;
   logic       bclk = 1'b1;
   logic       adclrc = 1'b1;
   logic       daclrc = 1'b1;
   logic       adcdat = 1'b0;
   logic       sclk, dacdat;
   logic [1:0] channel;
   wire        sdat;

   pullup (sdat);

   voice_transformer_top dut (
      .mclk    (mclk),
      .rst     (rst),
      .sclk    (sclk),
      .sdat    (sdat),
      .bclk    (bclk),
      .adclrc  (adclrc),
      .daclrc  (daclrc),
      .adcdat  (adcdat),
      .dacdat  (dacdat),
      .channel (channel)
   );

   // ---------------- clock / reset ----------------
   always #5 mclk = ~mclk;

   int cyc = 0;
   always @(posedge mclk) cyc++;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge mclk);
   endtask

   // ---------------- expected data ----------------
   logic [47:0] exp_q[$];   // {frame number, dac word}
   logic [7:0]  i2c_q[$];
   int          tb_frame = 0;
   int          stop_count = 0;
   bit          i2c_en = 1'b1;

   logic [7:0] cfg_bytes [0:26] = '{
      8'h34, 8'h1E, 8'h00,  8'h34, 8'h00, 8'h17,  8'h34, 8'h02, 8'h17,
      8'h34, 8'h08, 8'h12,  8'h34, 8'h0A, 8'h00,  8'h34, 8'h0C, 8'h00,
      8'h34, 8'h0E, 8'h42,  8'h34, 8'h10, 8'h00,  8'h34, 8'h12, 8'h01
   };

   logic [15:0] stream [0:9] = '{
      16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000, 16'hA55A,
      16'h0001, 16'h1357, 16'hFEDC, 16'h4000, 16'hC3C3
   };

   // ---------------- I2S driver ----------------
   task automatic drive_half(input logic lr, input logic [15:0] word, input int nbclk, input int rst_at);
      for (int i = 0; i < nbclk; i++) begin
         @(negedge mclk);
         bclk = 1'b0;
         if (i == 0) begin
            adclrc = lr;
            daclrc = lr;
            if (!lr) tb_frame++;
         end
         adcdat = (i >= 1 && i <= 16) ? word[16-i] : 1'b0;
         if (i == rst_at) rst = 1'b1;
         wait_neg(1);
         @(negedge mclk);
         bclk = 1'b1;
         wait_neg(1);
      end
   endtask

   task automatic drive_frame(input logic [15:0] lword, input logic [15:0] rword, input bit push);
      if (push) begin
         exp_q.push_back({32'(tb_frame + 2), lword});
         exp_q.push_back({32'(tb_frame + 2), lword});
      end
      drive_half(1'b0, lword, 32, -1);
      drive_half(1'b1, rword, 32, -1);
   endtask

   // ---------------- I2S monitor ----------------
   task automatic compare_half(input logic [15:0] got);
      while (exp_q.size() > 0 && int'(exp_q[0][47:16]) < tb_frame) begin
         checks++;
         errors++;
         $display("FAIL dacdat missed: got no word in frame %0d, required %h", int'(exp_q[0][47:16]), exp_q[0][15:0]);
         void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && int'(exp_q[0][47:16]) == tb_frame) begin
         check($sformatf("dacdat frame %0d lr %0b", tb_frame, adclrc), {16'h0, got}, {16'h0, exp_q[0][15:0]});
         void'(exp_q.pop_front());
      end
   endtask

   initial begin
      logic        prev_lr;
      int          n;
      logic [15:0] sh;
      prev_lr = 1'b1;
      n = 0;
      sh = '0;
      forever begin
         @(negedge bclk);
         #1;
         if (adclrc !== prev_lr) begin
            n = 0;
            prev_lr = adclrc;
         end else begin
            n++;
         end
         if (n >= 2 && n <= 17) sh = {sh[14:0], dacdat};
         if (n == 17) compare_half(sh);
      end
   end

   // ---------------- I2C monitor ----------------
   initial begin
      logic       ps, pd;
      int         bitc, last_rise;
      logic [7:0] by;
      ps = 1'b1;
      pd = 1'b1;
      bitc = 0;
      last_rise = -1;
      by = '0;
      forever begin
         @(negedge mclk);
         if (i2c_en && rst) begin
            if (ps && sclk && pd && !sdat) begin
               bitc = 0;
               last_rise = -1;
            end else if (ps && sclk && !pd && sdat) begin
               stop_count++;
               check("done low at stop", {31'h0, channel[1]}, 32'h0);
               last_rise = -1;
            end else if (!ps && sclk) begin
               if (last_rise >= 0) check("scl period", cyc - last_rise, 128);
               last_rise = cyc;
               if (bitc < 8) begin
                  by = {by[6:0], sdat};
                  bitc++;
               end else begin
                  check("ack released", {31'h0, sdat}, 32'h1);
                  if (i2c_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL i2c byte: got %h required none", by);
                  end else begin
                     check("i2c byte", {24'h0, by}, {24'h0, i2c_q.pop_front()});
                  end
                  bitc = 0;
               end
            end
         end
         ps = sclk;
         pd = sdat;
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      int t0, base, idle_bad;

      rst = 1'b0;
      wait_neg(10);
      check("reset sclk", {31'h0, sclk}, 32'h1);
      check("reset sdat", {31'h0, sdat}, 32'h1);
      check("reset dacdat", {31'h0, dacdat}, 32'h0);
      check("reset channel", {30'h0, channel}, 32'h0);
      for (int i = 0; i < 27; i++) i2c_q.push_back(cfg_bytes[i]);
      exp_q.push_back({32'd1, 16'h0000});
      exp_q.push_back({32'd1, 16'h0000});
      rst = 1'b1;
      wait_neg(4);

      fork
         begin
            drive_frame(16'h1234, 16'h0F0F, 1'b1);
            for (int i = 0; i < 10; i++) drive_frame(stream[i], ~stream[i], 1'b1);
            drive_frame(16'h0000, 16'h0000, 1'b0);
         end
         begin
            t0 = cyc;
            while (stop_count < 9 && cyc - t0 < 60000) @(negedge mclk);
            check("stop count", stop_count, 9);
            t0 = cyc;
            while (channel[1] !== 1'b1 && cyc - t0 < 2000) @(negedge mclk);
            check("config done", {31'h0, channel[1]}, 32'h1);
            check("i2c bytes left", i2c_q.size(), 0);
            idle_bad = 0;
            repeat (300) begin
               @(negedge mclk);
               if (sclk !== 1'b1 || sdat !== 1'b1) idle_bad++;
            end
            check("i2c idle after done", idle_bad, 0);
         end
      join

      // Reset in the middle of operation, then a truncated half.
      @(negedge mclk);
      rst = 1'b0;
      wait_neg(10);
      check("mid reset sclk", {31'h0, sclk}, 32'h1);
      check("mid reset dacdat", {31'h0, dacdat}, 32'h0);
      check("mid reset channel", {30'h0, channel}, 32'h0);
      base = stop_count;
      for (int i = 0; i < 3; i++) i2c_q.push_back(cfg_bytes[i]);
      drive_half(1'b0, 16'hFFFF, 32, 12);
      drive_half(1'b1, 16'h0000, 32, -1);
      exp_q.push_back({32'(tb_frame + 1), 16'h0000});
      exp_q.push_back({32'(tb_frame + 2), 16'h0000});
      exp_q.push_back({32'(tb_frame + 2), 16'h0000});
      drive_half(1'b0, 16'hFFFF, 10, -1);
      drive_half(1'b1, 16'h1111, 32, -1);
      drive_frame(16'hA5A5, 16'h5A5A, 1'b1);
      drive_frame(16'h0000, 16'h0000, 1'b0);
      check("done cleared after reset", {31'h0, channel[1]}, 32'h0);

      t0 = cyc;
      while ((stop_count == base || i2c_q.size() != 0) && cyc - t0 < 8000) @(negedge mclk);
      check("restart stop", stop_count, base + 1);
      check("restart bytes left", i2c_q.size(), 0);
      i2c_en = 1'b0;
      check("dac words left", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
